// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester command buses, grants and SDRAM pins around the arbiter
interface sdram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) ();
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;
    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DQ_W-1:0]   wr_data;
    logic              wr_en;
    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: SDRAM command-bus arbiter (init, then refresh > write > read); SDRAM_ARB_RR_EN enables write/read round-robin
module sdram_arbiter (
    input  logic           sys_clk,
    input  logic           sys_rst,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    state_t     state_q, state_d;
    logic       cke_q;
    logic       pick_rd;
    logic [3:0] cmd;

`ifdef SDRAM_ARB_RR_EN
    logic last_q;

    // Remember whether write (0) or read (1) was granted last
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            last_q <= 1'b0;
        else if (state_q == ARBIT && (state_d == WRITE || state_d == READ))
            last_q <= state_d == READ;
    end

    assign pick_rd = bus.rd_req & (~bus.wr_req | ~last_q);
`else
    assign pick_rd = bus.rd_req & ~bus.wr_req;
`endif

    // State register; async reset returns to INIT from anywhere
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            state_q <= INIT;
        else
            state_q <= state_d;
    end

    // Clock enable is held low in reset and high afterwards
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            cke_q <= 1'b0;
        else
            cke_q <= 1'b1;
    end

    // Next state: every operation returns to ARBIT, giving one NOP between operations
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = bus.init_end ? ARBIT : INIT;
            ARBIT:   state_d = bus.aref_req ? AREF : pick_rd ? READ : bus.wr_req ? WRITE : ARBIT;
            AREF:    state_d = bus.aref_end ? ARBIT : AREF;
            WRITE:   state_d = bus.wr_end ? ARBIT : WRITE;
            READ:    state_d = bus.rd_end ? ARBIT : READ;
            default: state_d = INIT;
        endcase
    end

    // Grants, command mux and DQ drive, all decoded from the state register
    always_comb begin
        bus.aref_en      = state_q == AREF;
        bus.wr_en        = state_q == WRITE;
        bus.rd_en        = state_q == READ;
        bus.sdram_cke    = cke_q;
        bus.sdram_dq_oe  = (state_q == WRITE) & bus.wr_sdram_en;
        bus.sdram_dq_out = ((state_q == WRITE) & bus.wr_sdram_en) ? bus.wr_data : '0;
        case (state_q)
            INIT: begin
                cmd            = bus.init_cmd;
                bus.sdram_ba   = bus.init_ba;
                bus.sdram_addr = bus.init_addr;
            end
            AREF: begin
                cmd            = bus.aref_cmd;
                bus.sdram_ba   = bus.aref_ba;
                bus.sdram_addr = bus.aref_addr;
            end
            WRITE: begin
                cmd            = bus.wr_cmd;
                bus.sdram_ba   = bus.wr_ba;
                bus.sdram_addr = bus.wr_addr;
            end
            READ: begin
                cmd            = bus.rd_cmd;
                bus.sdram_ba   = bus.rd_ba;
                bus.sdram_addr = bus.rd_addr;
            end
            default: begin
                cmd            = 4'b0111;
                bus.sdram_ba   = '1;
                bus.sdram_addr = '1;
            end
        endcase
        {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of init hold, priority, NOP gaps, DQ drive, stray ends and async reset
module tb_sdram_arbiter;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   tests   = 0;
    int   failed  = 0;

    sdram_arbiter_if #(.ADDR_W(13), .BA_W(2), .DQ_W(16)) bus ();

    sdram_arbiter dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_grants(input string tag, input logic a, input logic w, input logic r);
        chk({tag, ".aref_en"}, {31'd0, bus.aref_en}, {31'd0, a});
        chk({tag, ".wr_en"}, {31'd0, bus.wr_en}, {31'd0, w});
        chk({tag, ".rd_en"}, {31'd0, bus.rd_en}, {31'd0, r});
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        chk({tag, ".cmd"}, {28'd0, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n}, {28'd0, c});
        chk({tag, ".ba"}, {30'd0, bus.sdram_ba}, {30'd0, b});
        chk({tag, ".addr"}, {19'd0, bus.sdram_addr}, {19'd0, a});
    endtask

    initial begin
        bus.init_cmd = 4'b0010; bus.init_ba = 2'd1; bus.init_addr = 13'h0400; bus.init_end = 1'b0;
        bus.aref_req = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = 4'b0001; bus.aref_ba = 2'd0; bus.aref_addr = 13'h00AA;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = 4'b0100; bus.wr_ba = 2'd1; bus.wr_addr = 13'h0123;
        bus.wr_sdram_en = 1'b0; bus.wr_data = 16'h0000;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = 4'b0101; bus.rd_ba = 2'd2; bus.rd_addr = 13'h0456;

        // In reset: INIT, no grants, cke low, pins follow init bus
        repeat (3) tick();
        chk_grants("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.cke", {31'd0, bus.sdram_cke}, 32'd0);
        chk("rst.dq_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
        chk_pins("rst", 4'b0010, 2'd1, 13'h0400);

        // Init runs for 20000 cycles; pins keep showing the init command
        sys_rst = 1'b1;
        repeat (19999) tick();
        chk_grants("init", 1'b0, 1'b0, 1'b0);
        chk("init.cke", {31'd0, bus.sdram_cke}, 32'd1);
        chk_pins("init", 4'b0010, 2'd1, 13'h0400);
        bus.init_end = 1'b1;
        tick();
        chk_grants("arbit0", 1'b0, 1'b0, 1'b0);
        chk_pins("arbit0", 4'b0111, 2'd3, 13'h1FFF);

        // All three request together: refresh first
        bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        tick();
        chk_grants("pri.aref", 1'b1, 1'b0, 1'b0);
        chk_pins("pri.aref", 4'b0001, 2'd0, 13'h00AA);
        bus.aref_req = 1'b0; bus.aref_end = 1'b1;
        tick();
        bus.aref_end = 1'b0;
        chk_grants("pri.gap1", 1'b0, 1'b0, 1'b0);
        chk_pins("pri.gap1", 4'b0111, 2'd3, 13'h1FFF);
        // Fixed priority grants write; round-robin (write last at reset) grants read
        tick();
        chk_grants("pri.op1", 1'b0, !RR, RR);
        chk_pins("pri.op1", RR ? 4'b0101 : 4'b0100, RR ? 2'd2 : 2'd1, RR ? 13'h0456 : 13'h0123);
        bus.wr_req = RR; bus.rd_req = !RR;
        bus.wr_end = !RR; bus.rd_end = RR;
        tick();
        bus.wr_end = 1'b0; bus.rd_end = 1'b0;
        chk_grants("pri.gap2", 1'b0, 1'b0, 1'b0);
        tick();
        chk_grants("pri.op2", 1'b0, RR, !RR);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_end = RR; bus.rd_end = !RR;
        tick();
        bus.wr_end = 1'b0; bus.rd_end = 1'b0;
        chk_grants("pri.gap3", 1'b0, 1'b0, 1'b0);

        // Write: DQ driven only while the write controller says so; stray ends ignored
        bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        chk_grants("wr", 1'b0, 1'b1, 1'b0);
        bus.wr_sdram_en = 1'b1; bus.wr_data = 16'hA5A5;
        #1;
        chk("wr.dq_oe", {31'd0, bus.sdram_dq_oe}, 32'd1);
        chk("wr.dq_out", {16'd0, bus.sdram_dq_out}, 32'h0000A5A5);
        bus.wr_sdram_en = 1'b0;
        #1;
        chk("wr.dq_oe_off", {31'd0, bus.sdram_dq_oe}, 32'd0);
        chk("wr.dq_out_off", {16'd0, bus.sdram_dq_out}, 32'd0);
        bus.rd_end = 1'b1; bus.aref_end = 1'b1;
        tick();
        bus.rd_end = 1'b0; bus.aref_end = 1'b0;
        chk_grants("wr.stray", 1'b0, 1'b1, 1'b0);
        tick();
        chk_grants("wr.hold", 1'b0, 1'b1, 1'b0);
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        chk_grants("wr.done", 1'b0, 1'b0, 1'b0);

        // Read: DQ never driven even if wr_sdram_en is high
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk_grants("rd", 1'b0, 1'b0, 1'b1);
        chk_pins("rd", 4'b0101, 2'd2, 13'h0456);
        bus.wr_sdram_en = 1'b1; bus.wr_data = 16'hFFFF;
        #1;
        chk("rd.dq_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
        chk("rd.dq_out", {16'd0, bus.sdram_dq_out}, 32'd0);
        bus.wr_sdram_en = 1'b0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        chk_grants("rd.done", 1'b0, 1'b0, 1'b0);

        // Write and read both held: fixed priority always writes, round-robin alternates (read was last)
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grants($sformatf("alt%0d", i), 1'b0, !(RR && i[0]), RR && i[0]);
            bus.wr_end = !(RR && i[0]); bus.rd_end = RR && i[0];
            tick();
            bus.wr_end = 1'b0; bus.rd_end = 1'b0;
            chk_grants($sformatf("alt%0d.gap", i), 1'b0, 1'b0, 1'b0);
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;

        // Reset mid-write: grant drops at once, then init must finish again
        bus.wr_req = 1'b1;
        tick();
        chk_grants("mid.wr", 1'b0, 1'b1, 1'b0);
        #2;
        sys_rst = 1'b0;
        bus.init_end = 1'b0;
        #1;
        chk_grants("mid.rst", 1'b0, 1'b0, 1'b0);
        chk("mid.cke", {31'd0, bus.sdram_cke}, 32'd0);
        chk_pins("mid.rst", 4'b0010, 2'd1, 13'h0400);
        tick();
        sys_rst = 1'b1;
        repeat (5) tick();
        chk_grants("mid.init", 1'b0, 1'b0, 1'b0);
        chk_pins("mid.init", 4'b0010, 2'd1, 13'h0400);
        bus.init_end = 1'b1;
        tick();
        chk_grants("mid.arbit", 1'b0, 1'b0, 1'b0);
        tick();
        chk_grants("mid.regrant", 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
